// File: rtl/spi_target_word.sv
// SPI target with parametrised word width, CPOL/CPHA, bit order and a one-entry TX holding register.
// Optional feature macro SPI_TARGET_RX_HOLD_EN: holds rx_valid_o until rx_ack_i, flags rx_overrun_o.
module spi_target_word #(
  parameter int unsigned       WORD_W      = 8,
  parameter bit                CPOL        = 1'b0,
  parameter bit                CPHA        = 1'b0,
  parameter bit                MSB_FIRST   = 1'b1,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [WORD_W-1:0] TX_IDLE     = {WORD_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              spi_sck_i,
  input  logic              spi_copi_i,
  output logic              spi_cipo_o,
  input  logic              spi_cs_i,
  output logic              cs_active_o,
  output logic              rx_valid_o,
  output logic [WORD_W-1:0] rx_word_o,
  input  logic [WORD_W-1:0] tx_word_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_underrun_o,
  output logic              frame_abort_o
`ifdef SPI_TARGET_RX_HOLD_EN
  ,
  input  logic              rx_ack_i,
  output logic              rx_overrun_o
`endif
);
  localparam int unsigned CNT_W = $clog2(WORD_W);

  typedef enum logic {StIdle, StActive} state_e;

  // CS is synchronised as an active-high select so the reset value reads as "not selected".
  logic [SYNC_STAGES-1:0] r_sck_sync, r_copi_sync, r_cs_sync;
  logic                   r_sck_prev;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_sck_sync  <= '0;
      r_copi_sync <= '0;
      r_cs_sync   <= '0;
      r_sck_prev  <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi_copi_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], ~spi_cs_i};
      r_sck_prev  <= r_sck_sync[SYNC_STAGES-1];
    end
  end

  state_e             r_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [WORD_W-1:0]  r_rx_shift, r_rx_word, r_tx_shift, r_hold;
  logic               r_rx_valid, r_hold_full, r_underrun, r_abort;
`ifdef SPI_TARGET_RX_HOLD_EN
  logic               r_overrun;
`endif

  logic w_sck, w_copi, w_cs_act, w_rise, w_fall, w_lead, w_trail;
  logic w_in_frame, w_start, w_end, w_sample, w_shift, w_last, w_fetch, w_word_done, w_load;
  logic [WORD_W-1:0] w_rx_next, w_tx_shifted;

  assign w_sck    = r_sck_sync[SYNC_STAGES-1];
  assign w_copi   = r_copi_sync[SYNC_STAGES-1];
  assign w_cs_act = r_cs_sync[SYNC_STAGES-1];
  assign w_rise   = w_sck & ~r_sck_prev;
  assign w_fall   = ~w_sck & r_sck_prev;
  assign w_lead   = CPOL ? w_fall : w_rise;
  assign w_trail  = CPOL ? w_rise : w_fall;

  // CS release wins over any sck edge seen in the same cycle.
  assign w_in_frame  = (r_state == StActive) & w_cs_act;
  assign w_start     = (r_state == StIdle) & w_cs_act;
  assign w_end       = (r_state == StActive) & ~w_cs_act;
  assign w_sample    = w_in_frame & (CPHA ? w_trail : w_lead);
  assign w_shift     = w_in_frame & (CPHA ? w_lead : w_trail);
  assign w_last      = (r_bit_cnt == CNT_W'(WORD_W - 1));
  assign w_word_done = w_sample & w_last;
  assign w_fetch     = (w_shift & (r_bit_cnt == '0)) | (!CPHA & w_start);
  assign w_load      = tx_valid_i & ~r_hold_full;

  assign w_rx_next    = MSB_FIRST ? {r_rx_shift[WORD_W-2:0], w_copi}
                                  : {w_copi, r_rx_shift[WORD_W-1:1]};
  assign w_tx_shifted = MSB_FIRST ? {r_tx_shift[WORD_W-2:0], 1'b0}
                                  : {1'b0, r_tx_shift[WORD_W-1:1]};

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= StIdle;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_rx_word   <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_shift  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_underrun  <= 1'b0;
      r_abort     <= 1'b0;
`ifdef SPI_TARGET_RX_HOLD_EN
      r_overrun   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle:   if (w_cs_act)  r_state <= StActive;
        StActive: if (!w_cs_act) r_state <= StIdle;
        default:  r_state <= StIdle;
      endcase

      r_abort <= w_end & (r_bit_cnt != '0);
      if (w_end) begin
        r_bit_cnt  <= '0;
        r_rx_shift <= '0;
      end else if (w_sample) begin
        r_bit_cnt  <= w_last ? '0 : r_bit_cnt + 1'b1;
        r_rx_shift <= w_last ? '0 : w_rx_next;
      end

      if (w_word_done) r_rx_word <= w_rx_next;
`ifdef SPI_TARGET_RX_HOLD_EN
      r_overrun <= w_word_done & r_rx_valid & ~rx_ack_i;
      if (w_word_done)   r_rx_valid <= 1'b1;
      else if (rx_ack_i) r_rx_valid <= 1'b0;
`else
      r_rx_valid <= w_word_done;
`endif

      r_underrun <= w_fetch & ~r_hold_full;
      if (w_fetch)      r_tx_shift <= r_hold_full ? r_hold : TX_IDLE;
      else if (w_shift) r_tx_shift <= w_tx_shifted;

      // A load and a fetch in one cycle: the fetch already saw the empty register.
      if (w_load) begin
        r_hold      <= tx_word_i;
        r_hold_full <= 1'b1;
      end else if (w_fetch) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  assign spi_cipo_o    = MSB_FIRST ? r_tx_shift[WORD_W-1] : r_tx_shift[0];
  assign cs_active_o   = (r_state == StActive);
  assign rx_valid_o    = r_rx_valid;
  assign rx_word_o     = r_rx_word;
  assign tx_ready_o    = ~r_hold_full;
  assign tx_underrun_o = r_underrun;
  assign frame_abort_o = r_abort;
`ifdef SPI_TARGET_RX_HOLD_EN
  assign rx_overrun_o  = r_overrun;
`endif

endmodule

// File: doc/spi_target_word.md
Name: spi_target_word

Overview:
SPI target (peripheral) port with parametrised word width, full CPOL/CPHA mode support and bit order.
- Uses a one-entry TX holding register with valid/ready handshake.
- Reports underrun and aborted frames.
- Successor to the byte-wide mode-0 SPI target; sits between the external SPI pins and the register/command interface, clocked by the system clk (≥4x SCK).

Parameters:
WORD_W, 8, bits per SPI word (4..32)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge, shift on trailing; 1 = shift on leading, sample on trailing
MSB_FIRST, 1, 1 = MSB first on both COPI and CIPO; 0 = LSB first
SYNC_STAGES, 2, synchroniser flops on sck/copi/cs (≥2)
TX_IDLE, {WORD_W{1'b1}}, word sent when holding register empty

Ports:
clk  in  1  system clock
reset_i  in  1  reset; asynchronous, active-high
spi_sck_i  in  1  SPI clock
spi_copi_i  in  1  data from initiator
spi_cipo_o  out  1  data to initiator
spi_cs_i  in  1  target select, active-low
cs_active_o  out  1  synchronised CS asserted
rx_valid_o  out  1  rx_word_o valid (strobe; held if SPI_TARGET_RX_HOLD_EN)
rx_word_o  out  WORD_W  received word
tx_word_i  in  WORD_W  word to transmit
tx_valid_i  in  1  tx_word_i offered
tx_ready_o  out  1  holding register empty
tx_underrun_o  out  1  1-cycle pulse: TX_IDLE loaded because holding empty
frame_abort_o  out  1  1-cycle pulse: CS deasserted with partial word (bit count ≠ 0)

Behaviour:
Reset (async assert, sync release):
- All outputs 0 except tx_ready_o = 1.
- Shift registers, bit counter and synchronisers all 0.

Synchronisation and edges:
- sck, copi and cs each pass through SYNC_STAGES flops.
- Edges are detected from the last two synchronised sck samples.
- Leading edge = rise if CPOL=0, fall if CPOL=1; trailing edge = the opposite.
- Sample edge = leading if CPHA=0, else trailing; shift edge = the other.

States:
- IDLE (cs high) -> ACTIVE on synchronised cs low.
- ACTIVE -> IDLE on synchronised cs high, which takes priority over any same-cycle edge.
- While in IDLE, sck edges are ignored.

TX holding register:
- tx_ready_o = ~hold_full.
- tx_valid_i & tx_ready_o loads the holding register; tx_ready_o drops the next cycle.
- A load request and a same-cycle shift-register fetch: the fetch sees the old (empty) state.

TX shift register (spi_cipo_o = MSB if MSB_FIRST, else LSB):
- Fetch = load from holding register if full (hold becomes empty), else load TX_IDLE and pulse tx_underrun_o.
- CPHA=0: fetch on the IDLE->ACTIVE cycle and on the shift edge following the last bit of a word; shift on all other shift edges.
- CPHA=1: fetch on the shift edge of bit 0 of each word; shift on the other shift edges.

RX path:
- On each sample edge, shift copi into the rx shift register and increment the bit counter.
- When bit counter == WORD_W-1, counter wraps to 0. Next cycle: rx_word_o = assembled word (including this bit) and rx_valid_o pulses.
- Latency: 1 clk after the sampling sck edge is detected (SYNC_STAGES+1 clk from the pin edge).

CS deassert mid-word:
- Bit counter cleared, partial rx bits discarded, frame_abort_o pulses.
- The holding register is unaffected.
- The TX shift register keeps its content until the next fetch.

Back-to-back words within one CS frame are continuous; no gap is required.

Optional Feature:
SPI_TARGET_RX_HOLD_EN
- Defined: adds input rx_ack_i and output rx_overrun_o.
  - rx_valid_o stays high until rx_ack_i is sampled high.
  - If a new word completes while rx_valid_o is high, rx_word_o is overwritten, rx_valid_o stays high and rx_overrun_o pulses 1 cycle.
  - If rx_ack_i and a new word arrive in the same cycle, the new word wins: valid stays high and there is no overrun.
- Undefined: ports absent; rx_valid_o is a 1-cycle strobe and overwrite is silent.

Test Plan:
- Mode 0, WORD_W=8, MSB first, hold=0xA5 preloaded; initiator sends 0x3C -> rx_word_o=0x3C with one rx_valid_o pulse; initiator captures 0xA5; tx_ready_o returns to 1 at CS assertion.
- Mode 3 (CPOL=1, CPHA=1), WORD_W=16, LSB first, two back-to-back words 0x1234, 0xBEEF, hold refilled between them with 0x0F0F then 0xF0F0 -> rx_word_o sequence 0x1234, 0xBEEF; initiator receives 0x0F0F, 0xF0F0; no underrun.
- Hold empty at CS assert, TX_IDLE=0xFF -> initiator receives 0xFF; tx_underrun_o pulses exactly once.
- CS raised after 5 of 8 bits -> frame_abort_o pulse and no rx_valid_o. The next full frame carrying 0x81 -> rx_word_o=0x81.
- Assert reset_i mid-word (asynchronously, between clk edges) -> outputs clear immediately, tx_ready_o=1; the following frame carrying 0x55 is received correctly.
- With SPI_TARGET_RX_HOLD_EN and rx_ack_i held low across words 0x11, 0x22 -> rx_word_o=0x22, rx_valid_o stays 1, one rx_overrun_o pulse. rx_ack_i pulse -> rx_valid_o goes to 0.
